llc_cmd_sequencer: RTL and testbench

LLC_CMD_SEQUENCER -- requirements
Module: llc_cmd_sequencer

---
 rtl/llc_cmd_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_llc_cmd_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// llc_cmd_sequencer
//
// Per-command control sequencer for a last-level cache trace model. One
// command is accepted at a time from a trace stream. The sequencer looks the
// line up, writes back a dirty victim, issues bus transactions and snoop
// responses, and pulses the per-line MESI FSM. The command then retires with
// a one-cycle done pulse.
//
// State flow (every state except IDLE lasts exactly one cycle):
//   IDLE -> LOOKUP -> [WB] -> [BUS] -> [UPDATE] -> DONE -> IDLE    (CPU side)
//   IDLE -> LOOKUP -> RESP -> [BUS] -> [UPDATE] -> DONE -> IDLE    (snoops)
//
// Ports:
//   clk, rst_n         system clock; synchronous active-low reset
//   cmd_valid/ready    command handshake; ready only in IDLE
//   cmd[3:0]           trace opcode
//                      0 rd, 1 wr, 2 ifetch, 3 snoop inv, 4 snoop rd,
//                      5 snoop wr, 6 snoop rwim, 8 clear, 9 print
//   addr[31:0]         command address; latched into addr_q on accept
//   addr_q[31:0]       latched address presented to the tag array
//   hit, line_state,   tag array lookup result
//   victim_dirty       (sampled in LOOKUP only)
//   read_req,          one-cycle pulses to the per-line MESI FSM
//   write_req,
//   invalidate
//   bus_op[2:0]        0 none, 1 READ, 2 WRITE, 3 INVALIDATE, 4 RWIM
//   bus_op_valid       high in WB and BUS only
//   snoop_result[1:0]  0 NOHIT, 1 HIT, 2 HITM; qualified by snoop_valid
//   done               one-cycle retire pulse
//   err                one-cycle pulse in LOOKUP for an unknown opcode
//
// Optional feature (macro LLC_SEQ_STATS_EN):
//   hit_cnt[15:0], miss_cnt[15:0]  saturating lookup statistics for
//   opcodes 0-2. Both clear on opcode 8 and on reset.
// -----------------------------------------------------------------------------

package llc_line_pkg;

  // MESI state of the addressed line as reported by the tag array.
  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

endpackage

module llc_cmd_sequencer
  import llc_line_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd,
  input  logic [31:0] addr,

  output logic [31:0] addr_q,
  input  logic        hit,
  input  mesi_e       line_state,
  input  logic        victim_dirty,

  output logic        read_req,
  output logic        write_req,
  output logic        invalidate,

  output logic [2:0]  bus_op,
  output logic        bus_op_valid,

  output logic [1:0]  snoop_result,
  output logic        snoop_valid,
  output logic        done,
`ifdef LLC_SEQ_STATS_EN
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt,
`endif
  output logic        err
);

  // ---------------------------------------------------------------------------
  // Local types and opcodes
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_BUS,
    S_RESP,
    S_UPDATE,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    BUS_NONE  = 3'd0,
    BUS_READ  = 3'd1,
    BUS_WRITE = 3'd2,
    BUS_INV   = 3'd3,
    BUS_RWIM  = 3'd4
  } bus_e;

  // Which MESI pulse UPDATE produces; UPD_NONE means the command has no
  // UPDATE phase at all.
  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_READ,
    UPD_WRITE,
    UPD_INV
  } upd_e;

  typedef enum logic [1:0] {
    SNP_NOHIT = 2'd0,
    SNP_HIT   = 2'd1,
    SNP_HITM  = 2'd2
  } snp_e;

  localparam logic [3:0] OP_READ     = 4'd0;
  localparam logic [3:0] OP_WRITE    = 4'd1;
  localparam logic [3:0] OP_IFETCH   = 4'd2;
  localparam logic [3:0] OP_SNP_INV  = 4'd3;
  localparam logic [3:0] OP_SNP_RD   = 4'd4;
  localparam logic [3:0] OP_SNP_WR   = 4'd5;
  localparam logic [3:0] OP_SNP_RWIM = 4'd6;
  localparam logic [3:0] OP_CLEAR    = 4'd8;
  localparam logic [3:0] OP_PRINT    = 4'd9;

  // ---------------------------------------------------------------------------
  // State and per-command context
  // ---------------------------------------------------------------------------
  state_e     state, state_next;
  logic [3:0] cmd_q;
  bus_e       bus_q;    // operation issued in the BUS state
  upd_e       upd_q;    // pulse issued in the UPDATE state
  snp_e       snp_q;    // response driven in the RESP state

  // Plan for the rest of the command, decoded from the lookup result.
  // It is only meaningful, and only captured, while in LOOKUP.
  state_e     plan_next;
  bus_e       plan_bus;
  upd_e       plan_upd;
  snp_e       plan_snp;
  logic       plan_err;
  logic       line_hit;
  snp_e       snoop_class;

  logic       accept;

  assign accept = cmd_valid && cmd_ready;

  // A snoop only sees a hit when the line actually holds data.
  assign line_hit    = hit && (line_state != MESI_I);
  assign snoop_class = !line_hit              ? SNP_NOHIT :
                       (line_state == MESI_M) ? SNP_HITM  : SNP_HIT;

  // ---------------------------------------------------------------------------
  // Lookup decode: turn opcode + tag result into the remaining path
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default at the top so
  // that no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    plan_next = S_DONE;
    plan_bus  = BUS_NONE;
    plan_upd  = UPD_NONE;
    plan_snp  = SNP_NOHIT;
    plan_err  = 1'b0;

    unique case (cmd_q)
      OP_READ, OP_IFETCH: begin
        plan_upd = UPD_READ;
        if (hit) begin
          plan_next = S_UPDATE;
        end else begin
          plan_bus  = BUS_READ;
          plan_next = victim_dirty ? S_WB : S_BUS;
        end
      end

      OP_WRITE: begin
        plan_upd = UPD_WRITE;
        if (hit && (line_state == MESI_M || line_state == MESI_E)) begin
          plan_next = S_UPDATE;
        end else if (hit && line_state == MESI_S) begin
          // Other sharers must drop their copies before we own the line.
          plan_bus  = BUS_INV;
          plan_next = S_BUS;
        end else begin
          plan_bus  = BUS_RWIM;
          plan_next = victim_dirty ? S_WB : S_BUS;
        end
      end

      OP_SNP_RD: begin
        plan_snp  = snoop_class;
        plan_next = S_RESP;
        // A modified line is flushed to memory after signalling HITM.
        if (snoop_class == SNP_HITM) plan_bus = BUS_WRITE;
      end

      OP_SNP_INV, OP_SNP_RWIM: begin
        plan_snp  = snoop_class;
        plan_next = S_RESP;
        if (line_hit) begin
          plan_upd = UPD_INV;
          // Snooped RWIM takes ownership, so dirty data is flushed first.
          if (cmd_q == OP_SNP_RWIM && line_state == MESI_M)
            plan_bus = BUS_WRITE;
        end
      end

      OP_SNP_WR: begin
        plan_next = S_RESP;
      end

      OP_CLEAR, OP_PRINT: begin
        plan_next = S_DONE;
      end

      default: begin
        plan_err  = 1'b1;
        plan_next = S_DONE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and command context
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cmd_q  <= 4'd0;
      addr_q <= 32'd0;
      bus_q  <= BUS_NONE;
      upd_q  <= UPD_NONE;
      snp_q  <= SNP_NOHIT;
    end else begin
      state <= state_next;
      if (accept) begin
        cmd_q  <= cmd;
        addr_q <= addr;
      end
      if (state == S_LOOKUP) begin
        bus_q <= plan_bus;
        upd_q <= plan_upd;
        snp_q <= plan_snp;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    bus_op       = BUS_NONE;
    bus_op_valid = 1'b0;
    read_req     = 1'b0;
    write_req    = 1'b0;
    invalidate   = 1'b0;
    snoop_result = SNP_NOHIT;
    snoop_valid  = 1'b0;
    done         = 1'b0;
    err          = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (accept) state_next = S_LOOKUP;
      end

      S_LOOKUP: begin
        err        = plan_err;
        state_next = plan_next;
      end

      S_WB: begin
        bus_op       = BUS_WRITE;
        bus_op_valid = 1'b1;
        state_next   = S_BUS;
      end

      S_BUS: begin
        bus_op       = bus_q;
        bus_op_valid = 1'b1;
        state_next   = (upd_q != UPD_NONE) ? S_UPDATE : S_DONE;
      end

      S_RESP: begin
        snoop_result = snp_q;
        snoop_valid  = 1'b1;
        if (bus_q != BUS_NONE)      state_next = S_BUS;
        else if (upd_q != UPD_NONE) state_next = S_UPDATE;
        else                        state_next = S_DONE;
      end

      S_UPDATE: begin
        read_req   = (upd_q == UPD_READ);
        write_req  = (upd_q == UPD_WRITE);
        invalidate = (upd_q == UPD_INV);
        state_next = S_DONE;
      end

      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Ready is held low while reset is asserted, even though the state register
  // already reads IDLE.
  assign cmd_ready = (state == S_IDLE) && rst_n;

  // ---------------------------------------------------------------------------
  // Optional lookup statistics
  // ---------------------------------------------------------------------------
`ifdef LLC_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= 16'd0;
      miss_cnt <= 16'd0;
    end else if (state == S_LOOKUP) begin
      if (cmd_q == OP_CLEAR) begin
        hit_cnt  <= 16'd0;
        miss_cnt <= 16'd0;
      end else if (cmd_q == OP_READ || cmd_q == OP_WRITE || cmd_q == OP_IFETCH) begin
        if (hit) begin
          if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
        end else begin
          if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_llc_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_llc_cmd_sequencer
//
// Self-checking bench for llc_cmd_sequencer. Each command is expanded by a
// phase-list reference model into the cycle-by-cycle outputs expected after
// acceptance. Every cycle of the DUT is compared against that list. Lookup
// inputs are valid only in the LOOKUP cycle and are random elsewhere. Stray
// commands are presented while the DUT is busy. Statistics checks are
// compiled in when LLC_SEQ_STATS_EN is defined.
// -----------------------------------------------------------------------------

module tb_llc_cmd_sequencer;
  import llc_line_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd;
  logic [31:0] addr;
  logic [31:0] addr_q;
  logic        hit;
  mesi_e       line_state;
  logic        victim_dirty;
  logic        read_req, write_req, invalidate;
  logic [2:0]  bus_op;
  logic        bus_op_valid;
  logic [1:0]  snoop_result;
  logic        snoop_valid, done, err;
`ifdef LLC_SEQ_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  llc_cmd_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd          (cmd),
    .addr         (addr),
    .addr_q       (addr_q),
    .hit          (hit),
    .line_state   (line_state),
    .victim_dirty (victim_dirty),
    .read_req     (read_req),
    .write_req    (write_req),
    .invalidate   (invalidate),
    .bus_op       (bus_op),
    .bus_op_valid (bus_op_valid),
    .snoop_result (snoop_result),
    .snoop_valid  (snoop_valid),
    .done         (done),
`ifdef LLC_SEQ_STATS_EN
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
`endif
    .err          (err)
  );

  // One cycle's worth of observable per-command outputs.
  typedef struct packed {
    logic [2:0] bus;
    logic       bus_v;
    logic       rd;
    logic       wr;
    logic       inv;
    logic       sv;
    logic [1:0] sr;
    logic       er;
    logic       dn;
  } obs_t;

  int   checks = 0;
  int   errors = 0;
  int   n_cmds = 0;
  obs_t exp_q[$];

  function automatic obs_t ph(logic [2:0] b, logic rd, logic wr, logic inv,
                              logic sv, logic [1:0] sr, logic er, logic dn);
    obs_t o;
    o.bus = b;   o.bus_v = (b != 3'd0);
    o.rd = rd;   o.wr = wr;   o.inv = inv;
    o.sv = sv;   o.sr = sr;   o.er = er;   o.dn = dn;
    return o;
  endfunction

  function automatic obs_t observe();
    return ph(bus_op, read_req, write_req, invalidate, snoop_valid,
              snoop_result, err, done) | obs_t'({3'd0, bus_op_valid, 8'd0});
  endfunction

  // Reference model: list of per-cycle outputs from LOOKUP through DONE.
  task automatic model_cmd(input logic [3:0] op, input logic h,
                           input mesi_e ls, input logic d);
    logic [1:0] sr;
    exp_q.delete();
    exp_q.push_back(ph(3'd0, 0, 0, 0, 0, 2'd0, (op == 4'd7 || op > 4'd9), 0));
    sr = !h ? 2'd0 : (ls == MESI_M) ? 2'd2 : 2'd1;
    case (op)
      4'd0, 4'd2: begin
        if (!h) begin
          if (d) exp_q.push_back(ph(3'd2, 0, 0, 0, 0, 2'd0, 0, 0));
          exp_q.push_back(ph(3'd1, 0, 0, 0, 0, 2'd0, 0, 0));
        end
        exp_q.push_back(ph(3'd0, 1, 0, 0, 0, 2'd0, 0, 0));
      end
      4'd1: begin
        if (h && ls == MESI_S) begin
          exp_q.push_back(ph(3'd3, 0, 0, 0, 0, 2'd0, 0, 0));
        end else if (!h) begin
          if (d) exp_q.push_back(ph(3'd2, 0, 0, 0, 0, 2'd0, 0, 0));
          exp_q.push_back(ph(3'd4, 0, 0, 0, 0, 2'd0, 0, 0));
        end
        exp_q.push_back(ph(3'd0, 0, 1, 0, 0, 2'd0, 0, 0));
      end
      4'd4: begin
        exp_q.push_back(ph(3'd0, 0, 0, 0, 1, sr, 0, 0));
        if (sr == 2'd2) exp_q.push_back(ph(3'd2, 0, 0, 0, 0, 2'd0, 0, 0));
      end
      4'd3, 4'd6: begin
        exp_q.push_back(ph(3'd0, 0, 0, 0, 1, sr, 0, 0));
        if (h) begin
          if (op == 4'd6 && ls == MESI_M)
            exp_q.push_back(ph(3'd2, 0, 0, 0, 0, 2'd0, 0, 0));
          exp_q.push_back(ph(3'd0, 0, 0, 1, 0, 2'd0, 0, 0));
        end
      end
      4'd5: exp_q.push_back(ph(3'd0, 0, 0, 0, 1, 2'd0, 0, 0));
      default: ;
    endcase
    exp_q.push_back(ph(3'd0, 0, 0, 0, 0, 2'd0, 0, 1));
  endtask

  task automatic drive_noise();
    hit          = 1'($urandom_range(0, 1));
    line_state   = mesi_e'($urandom_range(0, 3));
    victim_dirty = 1'($urandom_range(0, 1));
  endtask

  // Entered and left at a falling edge while the DUT sits in IDLE.
  task automatic run_cmd(input logic [3:0] op, input logic [31:0] a,
                         input logic h, input mesi_e ls, input logic d);
    obs_t got;
    n_cmds++;
    model_cmd(op, h, ls, d);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_at_start cmd#%0d: cmd_ready=%b, required 1", n_cmds, cmd_ready);
    end
    cmd_valid = 1'b1; cmd = op; addr = a;
    drive_noise();
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(negedge clk);
      got = observe();
      checks++;
      if (got !== exp_q[k-1]) begin
        errors++;
        $display("FAIL timeline cmd#%0d op=%0d cycle+%0d: got bus=%0d/%b rd=%b wr=%b inv=%b snp=%b/%0d err=%b done=%b, required bus=%0d/%b rd=%b wr=%b inv=%b snp=%b/%0d err=%b done=%b",
                 n_cmds, op, k, got.bus, got.bus_v, got.rd, got.wr, got.inv, got.sv, got.sr, got.er, got.dn,
                 exp_q[k-1].bus, exp_q[k-1].bus_v, exp_q[k-1].rd, exp_q[k-1].wr, exp_q[k-1].inv,
                 exp_q[k-1].sv, exp_q[k-1].sr, exp_q[k-1].er, exp_q[k-1].dn);
      end
      checks++;
      if (cmd_ready !== 1'b0 || addr_q !== a) begin
        errors++;
        $display("FAIL busy_hold cmd#%0d cycle+%0d: cmd_ready=%b addr_q=%h, required 0 and %h",
                 n_cmds, k, cmd_ready, addr_q, a);
      end
      // Stray commands while busy must be ignored.
      cmd_valid = 1'($urandom_range(0, 1));
      cmd       = 4'($urandom_range(0, 15));
      addr      = $urandom;
      if (k == 1) begin
        hit = h; line_state = ls; victim_dirty = d;
      end else begin
        drive_noise();
      end
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || bus_op_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL return_idle cmd#%0d: cmd_ready=%b bus_op_valid=%b done=%b, required 1 0 0",
               n_cmds, cmd_ready, bus_op_valid, done);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = 4'd0; addr = 32'd0;
    hit = 1'b0; line_state = MESI_I; victim_dirty = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || addr_q !== 32'd0 || observe() !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_values: cmd_ready=%b addr_q=%h outputs=%h, required 0 0 0",
               cmd_ready, addr_q, observe());
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  task automatic test_directed();
    run_cmd(4'd0, 32'h0000_1000, 1'b1, MESI_E, 1'b0);   // read hit
    run_cmd(4'd0, 32'h0000_2000, 1'b0, MESI_M, 1'b1);   // dirty read miss
    run_cmd(4'd2, 32'h0000_2040, 1'b0, MESI_I, 1'b0);   // clean ifetch miss
    run_cmd(4'd1, 32'h0000_3000, 1'b1, MESI_S, 1'b0);   // write hit S
    run_cmd(4'd1, 32'h0000_3040, 1'b0, MESI_I, 1'b0);   // clean write miss
    run_cmd(4'd1, 32'h0000_3080, 1'b0, MESI_I, 1'b1);   // dirty write miss
    run_cmd(4'd1, 32'h0000_30C0, 1'b1, MESI_M, 1'b1);   // write hit M
    run_cmd(4'd4, 32'h0000_4000, 1'b1, MESI_M, 1'b0);   // snoop read HITM
    run_cmd(4'd4, 32'h0000_4040, 1'b0, MESI_I, 1'b0);   // snoop read miss
    run_cmd(4'd6, 32'h0000_5000, 1'b1, MESI_S, 1'b0);   // snoop rwim hit S
    run_cmd(4'd6, 32'h0000_5040, 1'b1, MESI_M, 1'b0);   // snoop rwim hit M
    run_cmd(4'd3, 32'h0000_5080, 1'b1, MESI_M, 1'b0);   // snoop inv hit M
    run_cmd(4'd5, 32'h0000_6000, 1'b1, MESI_E, 1'b0);   // snoop write
    run_cmd(4'd8, 32'h0000_0000, 1'b0, MESI_I, 1'b0);   // clear
    run_cmd(4'd9, 32'h0000_0000, 1'b1, MESI_E, 1'b0);   // print
    run_cmd(4'd7, 32'h0000_7000, 1'b1, MESI_M, 1'b1);   // illegal opcode
    run_cmd(4'd15, 32'hFFFF_FFFF, 1'b0, MESI_I, 1'b1);  // illegal opcode
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic       h;
    mesi_e      ls;
    for (int i = 0; i < 250; i++) begin
      op = 4'($urandom_range(0, 15));
      h  = 1'($urandom_range(0, 1));
      ls = h ? mesi_e'($urandom_range(1, 3)) : mesi_e'($urandom_range(0, 3));
      run_cmd(op, $urandom, h, ls, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_in_flight();
    cmd_valid = 1'b1; cmd = 4'd0; addr = 32'hDEAD_BEE0;
    @(negedge clk);                       // LOOKUP
    cmd_valid = 1'b0; hit = 1'b0; line_state = MESI_M; victim_dirty = 1'b1;
    @(negedge clk);                       // WB
    @(negedge clk);                       // BUS
    checks++;
    if (bus_op !== 3'd1 || bus_op_valid !== 1'b1) begin
      errors++;
      $display("FAIL inflight_bus: bus_op=%0d valid=%b, required 1 1", bus_op, bus_op_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_op_valid !== 1'b0 || cmd_ready !== 1'b0 || addr_q !== 32'd0 ||
        observe() !== obs_t'(0)) begin
      errors++;
      $display("FAIL inflight_reset: bus_op_valid=%b cmd_ready=%b addr_q=%h outputs=%h, required 0 0 0 0",
               bus_op_valid, cmd_ready, addr_q, observe());
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL inflight_idle: cmd_ready=%b, required 1", cmd_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (observe() !== obs_t'(0) || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL inflight_dropped cycle %0d: outputs=%h cmd_ready=%b, required 0 1",
                 k, observe(), cmd_ready);
      end
    end
  endtask

`ifdef LLC_SEQ_STATS_EN
  task automatic test_stats();
    run_cmd(4'd8, 32'd0, 1'b0, MESI_I, 1'b0);
    checks++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stats_clear0: hit_cnt=%0d miss_cnt=%0d, required 0 0", hit_cnt, miss_cnt);
    end
    for (int i = 0; i < 3; i++) run_cmd(4'd0, 32'h100 * i, 1'b1, MESI_E, 1'b0);
    run_cmd(4'd0, 32'h800, 1'b0, MESI_I, 1'b0);
    run_cmd(4'd4, 32'h900, 1'b1, MESI_M, 1'b0);   // snoops are not counted
    run_cmd(4'd3, 32'h940, 1'b0, MESI_I, 1'b0);
    checks++;
    if (hit_cnt !== 16'd3 || miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL stats_count: hit_cnt=%0d miss_cnt=%0d, required 3 1", hit_cnt, miss_cnt);
    end
    run_cmd(4'd8, 32'd0, 1'b1, MESI_E, 1'b0);
    checks++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stats_clear: hit_cnt=%0d miss_cnt=%0d, required 0 0", hit_cnt, miss_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_in_flight();
    test_directed();
`ifdef LLC_SEQ_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "simulation time limit reached");
  end

endmodule
